g9_clk_ctrl: RTL



---
 rtl/g9_pkg.sv | 23 ++
 rtl/g9_edge_det.sv | 22 ++
 rtl/g9_clk_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/g9_pkg.sv
// Shared definitions for the G9Processor clock-enable and reset sequencer.
// Mode encodings, sequencer state codes and the phase-length sanitising rule.
package g9_pkg;

   localparam logic [1:0] MODE_HALT  = 2'b00;
   localparam logic [1:0] MODE_RUN   = 2'b01;
   localparam logic [1:0] MODE_STEP  = 2'b10;
   localparam logic [1:0] MODE_BURST = 2'b11;

   typedef logic [2:0] state_t;

   localparam state_t ST_RST_HOLD = 3'd0;
   localparam state_t ST_IDLE     = 3'd1;
   localparam state_t ST_HIGH     = 3'd2;
   localparam state_t ST_LOW      = 3'd3;
   localparam state_t ST_GAP      = 3'd4;

   // A programmed length of zero would stall a phase forever, so it means one.
   function automatic logic [31:0] at_least_one(input logic [31:0] value);
      return (value == 32'd0) ? 32'd1 : value;
   endfunction

endpackage

// File: rtl/g9_edge_det.sv
// Registered rising-edge detector for an already-synchronised level input.
// The pulse appears one clk after the level is first sampled high.
module g9_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic level,
   output logic rise
);

   logic level_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         level_q <= 1'b0;
         rise    <= 1'b0;
      end else begin
         level_q <= level;
         rise    <= level & ~level_q;
      end
   end

endmodule

// File: rtl/g9_clk_ctrl.sv
// Clock-enable and reset sequencer for G9Processor: programmable HIGH/LOW/GAP
// phases, run/halt/step/burst modes, stretched reset and a retired-cycle counter.
module g9_clk_ctrl
   import g9_pkg::*;
#(
   parameter int DIV_W    = 16,
   parameter int GRP_W    = 4,
   parameter int CNT_W    = 32,
   parameter int BURST_W  = 8,
   parameter int RST_HOLD = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         mode,
   input  logic [DIV_W-1:0]   high_ticks,
   input  logic [DIV_W-1:0]   low_ticks,
   input  logic [DIV_W-1:0]   gap_ticks,
   input  logic [GRP_W-1:0]   cyc_per_gap,
   input  logic               step_req,
   input  logic [BURST_W-1:0] burst_len,
   output logic               cpu_clk,
   output logic               cpu_ce,
   output logic               cpu_rst,
   output logic               busy,
   output logic [CNT_W-1:0]   cycle_count
);

   localparam int HOLD_W = $clog2(RST_HOLD + 1);

   state_t             state, state_nx;
   logic [HOLD_W-1:0]  hold_cnt, hold_nx;
   logic [DIV_W-1:0]   phase_cnt, phase_nx;
   logic [GRP_W-1:0]   grp_cnt, grp_nx, grp_inc;
   logic [BURST_W-1:0] credit, credit_nx, credit_left;
   logic [CNT_W-1:0]   count_nx;
   logic               step_edge;
   logic               stepping;
   logic               decide;
   logic [DIV_W-1:0]   high_len, low_len;
   logic [GRP_W-1:0]   grp_len;

   g9_edge_det u_step_edge (
      .clk   (clk),
      .rst   (rst),
      .level (step_req),
      .rise  (step_edge)
   );

   assign high_len = DIV_W'(at_least_one(32'(high_ticks)));
   assign low_len  = DIV_W'(at_least_one(32'(low_ticks)));
   assign grp_len  = GRP_W'(at_least_one(32'(cyc_per_gap)));
   assign stepping = (mode == MODE_STEP) || (mode == MODE_BURST);
   assign grp_inc  = grp_cnt + GRP_W'(1);

   always_comb begin
      state_nx    = state;
      hold_nx     = hold_cnt;
      phase_nx    = phase_cnt;
      grp_nx      = grp_cnt;
      credit_nx   = credit;
      credit_left = credit;
      count_nx    = cycle_count;
      decide      = 1'b0;

      // Requests only grant credit when none is outstanding.
      if (step_edge && (credit == '0)) begin
         if (mode == MODE_STEP) begin
            credit_nx = BURST_W'(1);
         end else if (mode == MODE_BURST) begin
            credit_nx = burst_len;
         end
      end

      case (state)
         ST_RST_HOLD: begin
            if (hold_cnt <= HOLD_W'(1)) begin
               state_nx = ST_IDLE;
            end else begin
               hold_nx = hold_cnt - HOLD_W'(1);
            end
         end
         ST_IDLE: decide = 1'b1;
         ST_HIGH: begin
            if (phase_cnt == DIV_W'(1)) begin
               state_nx = ST_LOW;
               phase_nx = low_len;
            end else begin
               phase_nx = phase_cnt - DIV_W'(1);
            end
         end
         ST_LOW: begin
            if (phase_cnt == DIV_W'(1)) begin
               count_nx = cycle_count + CNT_W'(1);
               if (stepping && (credit != '0)) begin
                  credit_left = credit - BURST_W'(1);
                  credit_nx   = credit_left;
               end
               if (grp_inc >= grp_len) begin
                  grp_nx = '0;
                  if (gap_ticks != '0) begin
                     state_nx = ST_GAP;
                     phase_nx = gap_ticks;
                  end else begin
                     decide = 1'b1;
                  end
               end else begin
                  grp_nx = grp_inc;
                  decide = 1'b1;
               end
            end else begin
               phase_nx = phase_cnt - DIV_W'(1);
            end
         end
         ST_GAP: begin
            if (phase_cnt == DIV_W'(1)) begin
               decide = 1'b1;
            end else begin
               phase_nx = phase_cnt - DIV_W'(1);
            end
         end
         default: state_nx = ST_IDLE;
      endcase

      // Cycle-boundary decision; credit_left already reflects a final decrement.
      if (decide) begin
         if (mode == MODE_HALT) begin
            credit_nx = '0;
            state_nx  = ST_IDLE;
         end else if ((mode == MODE_RUN) || (credit_left != '0)) begin
            state_nx = ST_HIGH;
            phase_nx = high_len;
         end else begin
            state_nx = ST_IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_RST_HOLD;
         hold_cnt    <= HOLD_W'(RST_HOLD);
         phase_cnt   <= '0;
         grp_cnt     <= '0;
         credit      <= '0;
         cycle_count <= '0;
         cpu_clk     <= 1'b0;
         cpu_ce      <= 1'b0;
         cpu_rst     <= 1'b1;
         busy        <= 1'b0;
      end else begin
         state       <= state_nx;
         hold_cnt    <= hold_nx;
         phase_cnt   <= phase_nx;
         grp_cnt     <= grp_nx;
         credit      <= credit_nx;
         cycle_count <= count_nx;
         cpu_clk     <= (state_nx == ST_HIGH);
         cpu_ce      <= (state_nx == ST_HIGH) && (state != ST_HIGH);
         cpu_rst     <= (state_nx == ST_RST_HOLD);
         busy        <= (state_nx == ST_HIGH) || (state_nx == ST_LOW) || (state_nx == ST_GAP);
      end
   end

endmodule
